gray2dcba_tracker: RTL

//  Receive end of the team's DCBA->Gray path: samples a WIDTH-bit Gray code (e.g. rotary/position

---
 rtl/gray_pkg.sv | 30 +++
 rtl/gray2dcba_comb.sv | 18 +
 rtl/gray2dcba_tracker.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code receive path: tracker states,
// default widths and a width-generic Gray->binary decode function.
package gray_pkg;

  localparam int          MAX_W          = 32;
  localparam int unsigned GRAY_WIDTH_DEF = 4;
  localparam int unsigned POS_W_DEF      = 16;

  typedef enum logic [0:0] {
    ST_INIT,
    ST_TRACK
  } state_e;

  // Prefix-XOR of the code: b[i] = ^g[W-1:i]; bits at or above width are ignored.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g,
                                                input int unsigned       width);
    logic [MAX_W-1:0] gm;
    logic [MAX_W-1:0] b;
    gm = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < int'(width)) gm[i] = g[i];
    end
    b = gm;
    for (int s = 1; s < MAX_W; s++) begin
      b = b ^ (gm >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2dcba_comb.sv
// Pure combinational Gray -> binary (DCBA) decoder used by the tracker's second stage.
module gray2dcba_comb
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  logic [MAX_W-1:0] bin_full;

  always_comb begin
    bin_full = gray2bin(MAX_W'(gray_i), WIDTH);
    bin_o    = bin_full[WIDTH-1:0];
  end

endmodule

// File: rtl/gray2dcba_tracker.sv
// Samples a Gray code, decodes it to binary and tracks +1/-1 steps into a wrapping position.
// Optional saturating step-error counter when GRAY_ERRCNT_EN is defined.
module gray2dcba_tracker
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH_DEF,
  parameter int unsigned POS_W = POS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             dir_up,
  output logic             dir_dn,
  output logic             step_err,
  output logic [POS_W-1:0] position
`ifdef GRAY_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  logic [WIDTH-1:0] g_q, g_d;
  logic             v1_q;
  logic [WIDTH-1:0] bin_new;
  logic [WIDTH-1:0] delta;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             err_q, err_d;
  logic [POS_W-1:0] pos_q, pos_d;
  state_e           state_q, state_d;

  gray2dcba_comb #(
    .WIDTH (WIDTH)
  ) u_dec (
    .gray_i (g_q),
    .bin_o  (bin_new)
  );

  assign g_d   = in_valid ? gray_in : g_q;
  assign delta = bin_new - prev_q;

  always_comb begin
    out_valid_d = v1_q;
    bin_d       = bin_q;
    prev_d      = prev_q;
    state_d     = state_q;
    pos_d       = pos_q;
    up_d        = 1'b0;
    dn_d        = 1'b0;
    err_d       = 1'b0;
    if (v1_q) begin
      bin_d  = bin_new;
      prev_d = bin_new;
      if (state_q == ST_INIT) begin
        state_d = ST_TRACK;
      // +1 is tested first so that a 1-bit code reports any change as up.
      end else if (delta == WIDTH'(1)) begin
        up_d  = 1'b1;
        pos_d = pos_q + POS_W'(1);
      end else if (delta == '1) begin
        dn_d  = 1'b1;
        pos_d = pos_q - POS_W'(1);
      end else if (delta != '0) begin
        err_d = 1'b1;
      end
    end
    // Clear still lets the stage-2 sample land in bin_out/prev but drops its flags.
    if (clear) begin
      up_d    = 1'b0;
      dn_d    = 1'b0;
      err_d   = 1'b0;
      pos_d   = '0;
      state_d = ST_INIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q         <= '0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      bin_q       <= '0;
      prev_q      <= '0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      err_q       <= 1'b0;
      pos_q       <= '0;
      state_q     <= ST_INIT;
    end else begin
      g_q         <= g_d;
      v1_q        <= in_valid;
      out_valid_q <= out_valid_d;
      bin_q       <= bin_d;
      prev_q      <= prev_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
      err_q       <= err_d;
      pos_q       <= pos_d;
      state_q     <= state_d;
    end
  end

  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
  assign dir_up    = up_q;
  assign dir_dn    = dn_q;
  assign step_err  = err_q;
  assign position  = pos_q;

`ifdef GRAY_ERRCNT_EN
  logic [7:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = ecnt_q;
    if (clear) begin
      ecnt_d = '0;
    end else if (err_d && (ecnt_q != 8'hFF)) begin
      ecnt_d = ecnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt_q <= '0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign err_count = ecnt_q;
`endif

endmodule
